pn_checker: RTL

//  Serial PN-sequence checker; sits downstream of the pn_sequence LFSR generator (via link/DUT).

---
 rtl/pn_checker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pn_checker.sv
// Serial PN-sequence checker: self-synchronises a local Fibonacci LFSR to the received
// stream, declares lock, counts bit errors and drops lock on an excessive error burst.
module pn_checker #(
    parameter int             N          = 4,
    parameter logic [N-1:0]   TAP_MASK   = 4'b1100,
    parameter int             LOCK_CNT   = 8,
    parameter int             WINDOW     = 64,
    parameter int             ERR_THRESH = 8,
    parameter int             CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(ERR_THRESH + 1);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [FW-1:0]    FILL_LAST  = FW'(N - 1);
    localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0]    WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0]    ERR_LAST   = EW'(ERR_THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]    state;
    logic [N-1:0]  lfsr;
    logic [FW-1:0] fill_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    logic          pred;
    logic          mismatch;
    logic [N-1:0]  filled;

    assign pred     = ^(lfsr & TAP_MASK);
    assign mismatch = in_bit ^ pred;
    assign filled   = {lfsr[N-2:0], in_bit};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            lfsr      <= '1;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (in_valid) begin
            case (state)
                SEARCH: begin
                    lfsr <= filled;
                    if (fill_cnt == FILL_LAST) begin
                        fill_cnt <= '0;
                        // An all-zero register is the LFSR lock-up state; keep filling.
                        if (filled != '0) begin
                            state     <= VERIFY;
                            match_cnt <= '0;
                        end
                    end else begin
                        fill_cnt <= fill_cnt + FW'(1);
                    end
                end
                VERIFY: begin
                    lfsr <= {lfsr[N-2:0], pred};
                    if (mismatch) begin
                        state    <= SEARCH;
                        fill_cnt <= '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state   <= LOCKED;
                        locked  <= 1'b1;
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        match_cnt <= match_cnt + MW'(1);
                    end
                end
                LOCKED: begin
                    lfsr <= {lfsr[N-2:0], pred};
                    // Threshold is tested before the window wrap so a last-bit error still counts.
                    if (mismatch && (win_err == ERR_LAST)) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        fill_cnt <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                        win_err <= win_err + EW'(mismatch);
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked   <= 1'b0;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= in_valid && (state == LOCKED) && mismatch;
            if (clear_counts) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (in_valid && (state == LOCKED)) begin
                if (bit_count != CNT_MAX) bit_count <= bit_count + CNT_W'(1);
                if (mismatch && (err_count != CNT_MAX)) err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
